// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op codes, masks and
// interrupt bit positions.
package csr_pkg;

    localparam logic [3:0] CSR_MSTATUS   = 4'h0;
    localparam logic [3:0] CSR_MISA      = 4'h1;
    localparam logic [3:0] CSR_MIE       = 4'h2;
    localparam logic [3:0] CSR_MTVEC     = 4'h3;
    localparam logic [3:0] CSR_MEPC      = 4'h4;
    localparam logic [3:0] CSR_MCAUSE    = 4'h5;
    localparam logic [3:0] CSR_MTVAL     = 4'h6;
    localparam logic [3:0] CSR_MIP       = 4'h7;
    localparam logic [3:0] CSR_MSCRATCH  = 4'h8;
    localparam logic [3:0] CSR_MCYCLE    = 4'h9;
    localparam logic [3:0] CSR_MCYCLEH   = 4'hA;
    localparam logic [3:0] CSR_MINSTRET  = 4'hB;
    localparam logic [3:0] CSR_MINSTRETH = 4'hC;

    localparam logic [1:0] CSR_OP_R = 2'b00;
    localparam logic [1:0] CSR_OP_W = 2'b01;
    localparam logic [1:0] CSR_OP_S = 2'b10;
    localparam logic [1:0] CSR_OP_C = 2'b11;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
    localparam logic [31:0] MPP_FIXED     = 32'h0000_1800;
    localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
    localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

    localparam int unsigned IRQ_MEI = 11;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned MSTATUS_MIE = 3;

    // Value a CSR instruction writes back given the current register contents.
    function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] res;
        res = old_val;
        unique case (op)
            CSR_OP_W: res = wdata;
            CSR_OP_S: res = old_val | wdata;
            CSR_OP_C: res = old_val & ~wdata;
            default:  res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with separately writable halves; a write to either half
// takes priority over the increment in that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (we_lo || we_hi) begin
            if (we_lo) cnt_d[31:0]  = wdata;
            if (we_hi) cnt_d[63:32] = wdata;
        end else if (inc) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign value = cnt_q;

endmodule

// File: rtl/machine_csr_file.sv
// Machine-mode CSR storage shared by the trap controller and CSR instructions.
// Define CSR_COUNTERS_EN to implement the mcycle/minstret counters (addresses 9-C).
module machine_csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_handler_csr_write,
    input  logic [3:0]  trap_handler_add,
    input  logic [31:0] trap_handler_data,
    input  logic        trap_handler_add_src,
    input  logic        core_csr_we,
    input  logic [1:0]  core_csr_op,
    input  logic [3:0]  core_csr_add,
    input  logic [31:0] core_csr_wdata,
    input  logic        instret,
    input  logic        ext_irq,
    input  logic        sw_irq,
    input  logic        tmr_irq,
    output logic [31:0] csrOut,
    output logic        interruptRaised,
    output logic        machineExternalInterrupt,
    output logic        machineSoftwareInterrupt,
    output logic        machineTimerInterrupt
);

    logic [3:0]  sel_add;
    logic        wr_en;
    logic [31:0] wr_val;
    logic [31:0] rd_val;
    logic [31:0] counter_rd;

    logic [31:0] mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mip_q, mscratch_q;
    logic [31:0] mip_d;

    // Trap port fully owns the path when selected; core request is dropped.
    always_comb begin
        if (trap_handler_add_src) begin
            sel_add = trap_handler_add;
            wr_en   = trap_handler_csr_write;
            wr_val  = trap_handler_data;
        end else begin
            sel_add = core_csr_add;
            wr_en   = core_csr_we && (core_csr_op != CSR_OP_R);
            wr_val  = csr_apply_op(core_csr_op, rd_val, core_csr_wdata);
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel_add)
            CSR_MSTATUS:  rd_val = mstatus_q | MPP_FIXED;
            CSR_MISA:     rd_val = MISA_VAL;
            CSR_MIE:      rd_val = mie_q;
            CSR_MTVEC:    rd_val = mtvec_q;
            CSR_MEPC:     rd_val = mepc_q;
            CSR_MCAUSE:   rd_val = mcause_q;
            CSR_MTVAL:    rd_val = mtval_q;
            CSR_MIP:      rd_val = mip_q;
            CSR_MSCRATCH: rd_val = mscratch_q;
            default:      rd_val = counter_rd;
        endcase
    end

    assign csrOut = rd_val;

    // Source levels are OR'd in after the write so an asserted line cannot be cleared.
    always_comb begin
        mip_d = (wr_en && sel_add == CSR_MIP) ? (wr_val & MIE_MASK) : mip_q;
        mip_d[IRQ_MEI] = mip_d[IRQ_MEI] | ext_irq;
        mip_d[IRQ_MTI] = mip_d[IRQ_MTI] | tmr_irq;
        mip_d[IRQ_MSI] = mip_d[IRQ_MSI] | sw_irq;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST & MTVEC_WMASK;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
            mscratch_q <= '0;
        end else begin
            mip_q <= mip_d;
            if (wr_en) begin
                case (sel_add)
                    CSR_MSTATUS:  mstatus_q  <= wr_val & MSTATUS_WMASK;
                    CSR_MIE:      mie_q      <= wr_val & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= wr_val & MTVEC_WMASK;
                    CSR_MEPC:     mepc_q     <= wr_val & MEPC_WMASK;
                    CSR_MCAUSE:   mcause_q   <= wr_val;
                    CSR_MTVAL:    mtval_q    <= wr_val;
                    CSR_MSCRATCH: mscratch_q <= wr_val;
                    default:      ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .we_lo (wr_en && sel_add == CSR_MCYCLE),
        .we_hi (wr_en && sel_add == CSR_MCYCLEH),
        .wdata (wr_val),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instret),
        .we_lo (wr_en && sel_add == CSR_MINSTRET),
        .we_hi (wr_en && sel_add == CSR_MINSTRETH),
        .wdata (wr_val),
        .value (minstret)
    );

    always_comb begin
        counter_rd = '0;
        case (sel_add)
            CSR_MCYCLE:    counter_rd = mcycle[31:0];
            CSR_MCYCLEH:   counter_rd = mcycle[63:32];
            CSR_MINSTRET:  counter_rd = minstret[31:0];
            CSR_MINSTRETH: counter_rd = minstret[63:32];
            default:       counter_rd = '0;
        endcase
    end
`else
    logic unused_instret;
    assign unused_instret = instret;
    assign counter_rd     = '0;
`endif

    assign machineExternalInterrupt = mip_q[IRQ_MEI] & mie_q[IRQ_MEI];
    assign machineSoftwareInterrupt = mip_q[IRQ_MSI] & mie_q[IRQ_MSI];
    assign machineTimerInterrupt    = mip_q[IRQ_MTI] & mie_q[IRQ_MTI];
    assign interruptRaised = (machineExternalInterrupt | machineSoftwareInterrupt |
                              machineTimerInterrupt) & mstatus_q[MSTATUS_MIE];

endmodule

// File: tb/tb_machine_csr_file.sv
// Self-checking bench for machine_csr_file; counter checks follow CSR_COUNTERS_EN.
module tb_machine_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trap_handler_csr_write = 1'b0;
    logic [3:0]  trap_handler_add = '0;
    logic [31:0] trap_handler_data = '0;
    logic        trap_handler_add_src = 1'b0;
    logic        core_csr_we = 1'b0;
    logic [1:0]  core_csr_op = '0;
    logic [3:0]  core_csr_add = '0;
    logic [31:0] core_csr_wdata = '0;
    logic        instret = 1'b0;
    logic        ext_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic        tmr_irq = 1'b0;
    logic [31:0] csrOut;
    logic        interruptRaised;
    logic        machineExternalInterrupt;
    logic        machineSoftwareInterrupt;
    logic        machineTimerInterrupt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    machine_csr_file #(
        .MTVEC_RST (32'h0000_0000),
        .MISA_VAL  (32'h4000_0100)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .trap_handler_csr_write   (trap_handler_csr_write),
        .trap_handler_add         (trap_handler_add),
        .trap_handler_data        (trap_handler_data),
        .trap_handler_add_src     (trap_handler_add_src),
        .core_csr_we              (core_csr_we),
        .core_csr_op              (core_csr_op),
        .core_csr_add             (core_csr_add),
        .core_csr_wdata           (core_csr_wdata),
        .instret                  (instret),
        .ext_irq                  (ext_irq),
        .sw_irq                   (sw_irq),
        .tmr_irq                  (tmr_irq),
        .csrOut                   (csrOut),
        .interruptRaised          (interruptRaised),
        .machineExternalInterrupt (machineExternalInterrupt),
        .machineSoftwareInterrupt (machineSoftwareInterrupt),
        .machineTimerInterrupt    (machineTimerInterrupt)
    );

    always #20 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Expected value queued with the stimulus, popped when csrOut is sampled.
    task automatic sample(input string tag, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        #1;
        e = exp_q.pop_front();
        check_eq(tag, csrOut, e);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        core_csr_add = a;
        sample(tag, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic core_wr(input logic [3:0] a, input logic [1:0] op, input logic [31:0] d);
        core_csr_add   = a;
        core_csr_op    = op;
        core_csr_wdata = d;
        core_csr_we    = 1'b1;
        tick();
        core_csr_we = 1'b0;
        core_csr_op = 2'b00;
    endtask

    // Trap-port write with a competing core write; also checks the pre-edge old value.
    task automatic trap_wr(input string tag, input logic [3:0] a, input logic [31:0] d,
                           input logic [31:0] old);
        trap_handler_add_src   = 1'b1;
        trap_handler_add       = a;
        trap_handler_data      = d;
        trap_handler_csr_write = 1'b1;
        core_csr_we    = 1'b1;
        core_csr_op    = 2'b01;
        core_csr_add   = 4'h8;
        core_csr_wdata = 32'hDEAD_BEEF;
        sample(tag, old);
        tick();
        trap_handler_csr_write = 1'b0;
        trap_handler_add_src   = 1'b0;
        core_csr_we = 1'b0;
        core_csr_op = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        // Reset contents, sampled while reset is held.
        rd("rst_mstatus", 4'h0, 32'h0000_1800);
        rd("rst_misa", 4'h1, 32'h4000_0100);
        rd("rst_mtvec", 4'h3, 32'h0000_0000);
        for (int a = 2; a <= 15; a++) begin
            if (a != 3) rd($sformatf("rst_addr%0d", a), 4'(a), 32'h0);
        end
        check_eq("rst_irq", {28'h0, interruptRaised, machineExternalInterrupt,
                             machineSoftwareInterrupt, machineTimerInterrupt}, 32'h0);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
`ifdef CSR_COUNTERS_EN
            rd($sformatf("mcycle_run%0d", i), 4'h9, 32'(i));
`else
            rd($sformatf("mcycle_off%0d", i), 4'h9, 32'h0);
`endif
        end

        // Trap entry through the trap port.
        trap_wr("trap_old_mcause", 4'h5, 32'h8000_000B, 32'h0);
        trap_wr("trap_old_mepc", 4'h4, 32'h0000_0123, 32'h0);
        trap_wr("trap_old_mstatus", 4'h0, 32'h0000_1980, 32'h0000_1800);
        rd("trap_mcause", 4'h5, 32'h8000_000B);
        rd("trap_mepc", 4'h4, 32'h0000_0120);
        rd("trap_mstatus", 4'h0, 32'h0000_1880);
        rd("trap_core_ignored", 4'h8, 32'h0);

        // Enable external interrupt through CSRRS.
        ext_irq = 1'b1;
        core_wr(4'h2, 2'b10, 32'h0000_0888);
        rd("mie_set", 4'h2, 32'h0000_0888);
        rd("mip_ext", 4'h7, 32'h0000_0800);
        check_eq("mei_pending", {31'h0, machineExternalInterrupt}, 32'h1);
        check_eq("raised_mie0", {31'h0, interruptRaised}, 32'h0);
        core_wr(4'h0, 2'b10, 32'h0000_0008);
        rd("mstatus_mie", 4'h0, 32'h0000_1888);
        check_eq("raised_ext", {31'h0, interruptRaised}, 32'h1);

        // Timer level holds mip[7] against a write of 0.
        ext_irq = 1'b0;
        tmr_irq = 1'b1;
        core_wr(4'h7, 2'b01, 32'h0);
        rd("mip_tmr_held", 4'h7, 32'h0000_0080);
        check_eq("irq_tmr", {29'h0, machineExternalInterrupt, machineTimerInterrupt,
                             interruptRaised}, 32'h3);
        tmr_irq = 1'b0;
        core_wr(4'h7, 2'b01, 32'h0);
        rd("mip_clear", 4'h7, 32'h0);
        check_eq("raised_none", {31'h0, interruptRaised}, 32'h0);

        // Read-only op must not write; software irq latches into mip[3].
        sw_irq = 1'b1;
        core_wr(4'h8, 2'b00, 32'h5555_5555);
        rd("op_read_nowrite", 4'h8, 32'h0);
        check_eq("irq_sw", {30'h0, machineSoftwareInterrupt, interruptRaised}, 32'h3);
        sw_irq = 1'b0;
        core_wr(4'h7, 2'b11, 32'h0000_0008);
        rd("mip_csrrc", 4'h7, 32'h0);

        // Field masks.
        core_wr(4'h3, 2'b01, 32'h0000_1003);
        rd("mtvec_mode", 4'h3, 32'h0000_1001);
        core_wr(4'h3, 2'b11, 32'h0000_0001);
        rd("mtvec_clr", 4'h3, 32'h0000_1000);
        core_wr(4'h4, 2'b01, 32'hFFFF_FFFF);
        rd("mepc_align", 4'h4, 32'hFFFF_FFFC);
        core_wr(4'h1, 2'b01, 32'h0);
        rd("misa_ro", 4'h1, 32'h4000_0100);
        core_wr(4'hD, 2'b01, 32'hFFFF_FFFF);
        rd("addr_d_zero", 4'hD, 32'h0);
        core_wr(4'h6, 2'b01, 32'hCAFE_F00D);
        rd("mtval_full", 4'h6, 32'hCAFE_F00D);
        core_wr(4'h0, 2'b01, 32'hFFFF_FFFF);
        rd("mstatus_mask", 4'h0, 32'h0000_1888);

        // Write latency: old value visible before the edge, new value after.
        core_csr_add = 4'h8; core_csr_op = 2'b01; core_csr_wdata = 32'h1234_5678;
        core_csr_we = 1'b1;
        sample("mscratch_same_cycle", 32'h0);
        tick();
        core_csr_we = 1'b0; core_csr_op = 2'b00;
        rd("mscratch_next", 4'h8, 32'h1234_5678);

`ifdef CSR_COUNTERS_EN
        core_wr(4'h9, 2'b01, 32'hFFFF_FFFF);
        core_wr(4'hA, 2'b01, 32'hFFFF_FFFF);
        rd("mcycle_ones_lo", 4'h9, 32'hFFFF_FFFF);
        rd("mcycle_ones_hi", 4'hA, 32'hFFFF_FFFF);
        tick();
        tick();
        rd("mcycle_wrap_lo", 4'h9, 32'h1);
        rd("mcycle_wrap_hi", 4'hA, 32'h0);
        rd("minstret_idle", 4'hB, 32'h0);
        instret = 1'b1;
        core_wr(4'hB, 2'b01, 32'h10);
        rd("minstret_wr_pri", 4'hB, 32'h10);
        tick();
        instret = 1'b0;
        tick();
        tick();
        rd("minstret_pulse", 4'hB, 32'h11);
        instret = 1'b1;
        tick();
        instret = 1'b0;
        core_wr(4'hC, 2'b01, 32'h7);
        rd("minstret_lo", 4'hB, 32'h12);
        rd("minstreth", 4'hC, 32'h7);
`else
        for (int a = 9; a <= 12; a++) begin
            instret = 1'b1;
            core_wr(4'(a), 2'b01, 32'hFFFF_FFFF);
            instret = 1'b0;
            rd($sformatf("counter_off%0d", a), 4'(a), 32'h0);
        end
`endif

        // Reset during a pending write: the write is lost.
        core_csr_add = 4'h8; core_csr_op = 2'b01; core_csr_wdata = 32'hAAAA_AAAA;
        core_csr_we = 1'b1;
        #5;
        rst = 1'b0;
        tick();
        core_csr_we = 1'b0; core_csr_op = 2'b00;
        rst = 1'b1;
        rd("rst_midwrite", 4'h8, 32'h0);
        rd("rst_mstatus2", 4'h0, 32'h0000_1800);
        rd("rst_mie2", 4'h2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
